// File: rtl/bus_pkg.sv
// Shared types and constants for the indirect bus-op arbiter.
// Optional feature in the top: BUS_ARB_ROUND_ROBIN_EN (rotating priority).
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        COMPLETE
    } arbState_t;

    localparam logic [2:0] SEG_ES   = 3'd0;
    localparam logic [2:0] SEG_CS   = 3'd1;
    localparam logic [2:0] SEG_SS   = 3'd2;
    localparam logic [2:0] SEG_DS   = 3'd3;
    localparam logic [2:0] SEG_ZERO = 3'd4;

    // Fields handed to the bus interface for one indirect bus op
    typedef struct packed {
        logic [15:0] ind;
        logic [15:0] wdata;
        logic [2:0]  seg;
        logic        ioMreq;
        logic        readWrite;
        logic        byteWord;
    } busOp_t;

    // Quiescent field values: memory space, read, byte, zero segment
    localparam busOp_t BUS_OP_IDLE = '{
        ind:       16'h0000,
        wdata:     16'h0000,
        seg:       SEG_ZERO,
        ioMreq:    1'b1,
        readWrite: 1'b0,
        byteWord:  1'b0
    };

    // Any select with the top bit set means the zero segment
    function automatic logic [2:0] normSeg(input logic [2:0] sel);
        return sel[2] ? SEG_ZERO : sel;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational one-hot picker: first active request found when searching
// upward (with wrap) from startPtr.
module bus_arb_pick
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      startPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grantIdx,
    output logic               anyReq
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Walk the requesters starting at startPtr and take the first one set
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, startPtr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx;
            end
        end
        anyReq = found;
    end

endmodule

// File: rtl/bus_request_arbiter.sv
// Shares the bus interface's indirect operand channel between NUM_REQ
// execution-side requesters. One op at a time: latch the winner's fields,
// strobe 'indirect', wait out the bus op (with timeout), return data + done.
// Build option: BUS_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise
// lowest index wins.
module bus_request_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [3*NUM_REQ-1:0]  req_seg,
    input  logic [16*NUM_REQ-1:0] req_ind,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_io,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ-1:0]    req_word,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [15:0]           rdata,
    output logic                  indirect,
    output logic [15:0]           IND,
    output logic [15:0]           OPRw,
    output logic [2:0]            indirectSeg,
    output logic                  ind_ioMreq,
    output logic                  ind_readWrite,
    output logic                  ind_byteWord,
    input  logic [15:0]           OPRr,
    input  logic                  indirectBusOpInProgress
);

    localparam int          IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arbState_t          state, stateNext;
    logic [15:0]        cycleCnt;
    logic [NUM_REQ-1:0] ownerOh, pickOh;
    logic [IW-1:0]      pickIdx, startPtr;
    logic               pickAny;
    busOp_t             busOp, pickOp;
    logic               errFlag;
    logic               loadOp, clearCnt, captureRd, timeoutHit;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] lastOwner;

    // Remember the most recent owner so the search starts just past it
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            lastOwner <= IW'(NUM_REQ - 1);
        end else if (loadOp) begin
            lastOwner <= pickIdx;
        end
    end

    assign startPtr = (lastOwner == IW'(NUM_REQ - 1)) ? '0 : lastOwner + 1'b1;
`else
    assign startPtr = '0;
`endif

    bus_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req      (req),
        .startPtr (startPtr),
        .grant    (pickOh),
        .grantIdx (pickIdx),
        .anyReq   (pickAny)
    );

    // Gather the winning requester's bus-op fields from the packed request buses
    always_comb begin
        pickOp = BUS_OP_IDLE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickOh[i]) begin
                pickOp = '{
                    ind:       req_ind[16*i +: 16],
                    wdata:     req_wdata[16*i +: 16],
                    seg:       normSeg(req_seg[3*i +: 3]),
                    ioMreq:    ~req_io[i],
                    readWrite: req_write[i],
                    byteWord:  req_word[i]
                };
            end
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and control strobes
    always_comb begin
        stateNext  = state;
        loadOp     = 1'b0;
        clearCnt   = 1'b0;
        captureRd  = 1'b0;
        timeoutHit = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickAny) begin
                    stateNext = LAUNCH;
                    loadOp    = 1'b1;
                    clearCnt  = 1'b1;
                end
            end
            LAUNCH: begin
                if (cycleCnt == STROBE_LAST) begin
                    stateNext = SETTLE;
                    clearCnt  = 1'b1;
                end
            end
            SETTLE: begin
                stateNext = WAIT;
                clearCnt  = 1'b1;
            end
            WAIT: begin
                if (!indirectBusOpInProgress) begin
                    stateNext = COMPLETE;
                    captureRd = 1'b1;
                end else if (cycleCnt == TIMEOUT_LAST) begin
                    stateNext  = COMPLETE;
                    captureRd  = 1'b1;
                    timeoutHit = 1'b1;
                end
            end
            COMPLETE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Phase counter, latched op fields, owner, read data and error flag.
    // Read data is taken on the edge into COMPLETE so it is valid with done.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            cycleCnt <= '0;
            busOp    <= BUS_OP_IDLE;
            ownerOh  <= '0;
            rdata    <= '0;
            errFlag  <= 1'b0;
        end else begin
            if (clearCnt) begin
                cycleCnt <= '0;
            end else if (state == LAUNCH || state == WAIT) begin
                cycleCnt <= cycleCnt + 16'd1;
            end
            if (loadOp) begin
                busOp   <= pickOp;
                ownerOh <= pickOh;
            end
            if (captureRd) begin
                rdata   <= OPRr;
                errFlag <= timeoutHit;
            end
        end
    end

    assign indirect      = (state == LAUNCH);
    assign gnt           = (state != IDLE) ? ownerOh : '0;
    assign done          = (state == COMPLETE) ? ownerOh : '0;
    assign err           = (state == COMPLETE) && errFlag;
    assign IND           = busOp.ind;
    assign OPRw          = busOp.wdata;
    assign indirectSeg   = busOp.seg;
    assign ind_ioMreq    = busOp.ioMreq;
    assign ind_readWrite = busOp.readWrite;
    assign ind_byteWord  = busOp.byteWord;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Directed bench for bus_request_arbiter with a completion scoreboard.
// Contention expectations follow BUS_ARB_ROUND_ROBIN_EN when defined.
module tb_bus_request_arbiter;

    localparam int N  = 3;
    localparam int SC = 2;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RESET_n;
    always #5 CLK = ~CLK;

    logic        reqArr[N];
    logic [2:0]  segArr[N];
    logic [15:0] indArr[N];
    logic [15:0] wdArr[N];
    logic        ioArr[N];
    logic        wrArr[N];
    logic        wordArr[N];

    logic [N-1:0]    req, req_io, req_write, req_word;
    logic [3*N-1:0]  req_seg;
    logic [16*N-1:0] req_ind, req_wdata;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req[g]               = reqArr[g];
        assign req_io[g]            = ioArr[g];
        assign req_write[g]         = wrArr[g];
        assign req_word[g]          = wordArr[g];
        assign req_seg[3*g +: 3]    = segArr[g];
        assign req_ind[16*g +: 16]  = indArr[g];
        assign req_wdata[16*g +: 16] = wdArr[g];
    end

    logic [N-1:0] gnt, done;
    logic         err, indirect, ind_ioMreq, ind_readWrite, ind_byteWord;
    logic [15:0]  rdata, IND, OPRw, OPRr;
    logic [2:0]   indirectSeg;
    logic         busy;

    bus_request_arbiter #(
        .NUM_REQ        (N),
        .STROBE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK                     (CLK),
        .RESET_n                 (RESET_n),
        .req                     (req),
        .req_seg                 (req_seg),
        .req_ind                 (req_ind),
        .req_wdata               (req_wdata),
        .req_io                  (req_io),
        .req_write               (req_write),
        .req_word                (req_word),
        .gnt                     (gnt),
        .done                    (done),
        .err                     (err),
        .rdata                   (rdata),
        .indirect                (indirect),
        .IND                     (IND),
        .OPRw                    (OPRw),
        .indirectSeg             (indirectSeg),
        .ind_ioMreq              (ind_ioMreq),
        .ind_readWrite           (ind_readWrite),
        .ind_byteWord            (ind_byteWord),
        .OPRr                    (OPRr),
        .indirectBusOpInProgress (busy)
    );

    logic [37:0] obsFields;
    assign obsFields = {IND, OPRw, indirectSeg, ind_ioMreq, ind_readWrite, ind_byteWord};

    typedef struct {
        int          owner;
        logic [15:0] rdata;
        bit          chkData;
        bit          err;
        logic [37:0] fields;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bus fields for requester r, from the requester's own inputs
    function automatic logic [37:0] modelFields(input int r);
        logic [2:0] s;
        s = (segArr[r] >= 3'd4) ? 3'd4 : segArr[r];
        return {indArr[r], wdArr[r], s, ~ioArr[r], wrArr[r], wordArr[r]};
    endfunction

    task automatic pushExp(input int r, input logic [15:0] rd, input bit chk, input bit e);
        exp_t x;
        x.owner   = r;
        x.rdata   = rd;
        x.chkData = chk;
        x.err     = e;
        x.fields  = modelFields(r);
        sbq.push_back(x);
    endtask

    task automatic setReq(input int r, input logic [2:0] s, input logic [15:0] ind,
                          input logic [15:0] wd, input logic io, input logic wr, input logic word);
        segArr[r]  = s;
        indArr[r]  = ind;
        wdArr[r]   = wd;
        ioArr[r]   = io;
        wrArr[r]   = wr;
        wordArr[r] = word;
        reqArr[r]  = 1'b1;
    endtask

    // Sample on negedges until done; busy drops at iteration dropAt (if >0).
    // Iteration k sees the state after the k-th posedge following the call.
    task automatic waitDone(input string name, input int budget, input int dropAt,
                            output int waited, output int indCnt);
        exp_t        e;
        bit          gotDone;
        bit          fieldBad;
        logic [63:0] oh;
        gotDone  = 1'b0;
        fieldBad = 1'b0;
        waited   = 0;
        indCnt   = 0;
        e        = sbq[0];
        for (int k = 1; k <= budget && !gotDone; k++) begin
            @(negedge CLK);
            waited = k;
            if (indirect) indCnt++;
            if (|gnt && obsFields !== e.fields) fieldBad = 1'b1;
            if (|done) begin
                gotDone = 1'b1;
                e  = sbq.pop_front();
                oh = 64'(1) << e.owner;
                check({name, "_done"}, 64'(done), oh);
                check({name, "_gnt"}, 64'(gnt), oh);
                check({name, "_err"}, 64'(err), 64'(e.err));
                if (e.chkData) check({name, "_rdata"}, 64'(rdata), 64'(e.rdata));
                check({name, "_fields_stable"}, 64'(fieldBad), 64'(0));
            end else if (k == dropAt) begin
                busy = 1'b0;
            end
        end
        checks++;
        assert (gotDone) else begin
            failures++;
            $error("FAIL %s_wait observed=no_done expected=done", name);
        end
    endtask

    task automatic checkReset(input string name);
        check({name, "_gnt"},   64'(gnt), 64'(0));
        check({name, "_done"},  64'(done), 64'(0));
        check({name, "_err"},   64'(err), 64'(0));
        check({name, "_ind"},   64'(indirect), 64'(0));
        check({name, "_rdata"}, 64'(rdata), 64'(0));
        check({name, "_IND"},   64'(IND), 64'(0));
        check({name, "_OPRw"},  64'(OPRw), 64'(0));
        check({name, "_seg"},   64'(indirectSeg), 64'(4));
        check({name, "_iom"},   64'(ind_ioMreq), 64'(1));
        check({name, "_rw"},    64'(ind_readWrite), 64'(0));
        check({name, "_bw"},    64'(ind_byteWord), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int w, ic, cnt;
        int owners[$];
        for (int i = 0; i < N; i++) begin
            reqArr[i] = 1'b0; segArr[i] = '0; indArr[i] = '0; wdArr[i] = '0;
            ioArr[i] = 1'b0; wrArr[i] = 1'b0; wordArr[i] = 1'b0;
        end
        busy    = 1'b0;
        OPRr    = '0;
        RESET_n = 1'b0;
        repeat (2) @(negedge CLK);
        checkReset("reset");
        RESET_n = 1'b1;
        @(negedge CLK);
        check("idle_gnt", 64'(gnt), 64'(0));

        // Single word read on req0, DS, busy held 5 WAIT cycles
        OPRr = 16'hBEEF;
        busy = 1'b1;
        setReq(0, 3'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
        pushExp(0, 16'hBEEF, 1'b1, 1'b0);
        waitDone("read", 40, SC + 7, w, ic);
        reqArr[0] = 1'b0;
        check("read_latency", 64'(w), 64'(SC + 8));
        check("read_strobe", 64'(ic), 64'(SC));
        repeat (2) @(negedge CLK);
        check("read_rdata_held", 64'(rdata), 64'(16'hBEEF));
        check("read_done_off", 64'(done), 64'(0));

        // Byte write to IO space on req1
        busy = 1'b1;
        setReq(1, 3'd1, 16'h0042, 16'h00A5, 1'b1, 1'b1, 1'b0);
        pushExp(1, 16'h0000, 1'b0, 1'b0);
        waitDone("write", 40, SC + 3, w, ic);
        reqArr[1] = 1'b0;
        check("write_OPRw", 64'(OPRw), 64'(16'h00A5));
        check("write_rw", 64'(ind_readWrite), 64'(1));
        check("write_iom", 64'(ind_ioMreq), 64'(0));
        check("write_bw", 64'(ind_byteWord), 64'(0));
        @(negedge CLK);

        // Minimum latency on req2 (busy already low); also leaves req2 as last owner
        busy = 1'b0;
        OPRr = 16'h1357;
        setReq(2, 3'd0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
        pushExp(2, 16'h1357, 1'b1, 1'b0);
        waitDone("minlat", 40, -1, w, ic);
        reqArr[2] = 1'b0;
        check("minlat_latency", 64'(w), 64'(SC + 3));
        @(negedge CLK);

        // Contention between req0 and req2, both held throughout
        OPRr = 16'h5A5A;
        setReq(0, 3'd3, 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b1);
        setReq(2, 3'd2, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b1);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        owners = '{0, 2, 0, 2};
`else
        owners = '{0, 0, 0};
`endif
        foreach (owners[i]) pushExp(owners[i], 16'h5A5A, 1'b1, 1'b0);
        foreach (owners[i]) waitDone($sformatf("contend%0d", i), 40, -1, w, ic);
        reqArr[0] = 1'b0;
        reqArr[2] = 1'b0;
        @(negedge CLK);

        // Timeout: busy stuck high
        busy = 1'b1;
        setReq(1, 3'd3, 16'h0777, 16'h0000, 1'b0, 1'b0, 1'b1);
        pushExp(1, 16'h0000, 1'b0, 1'b1);
        waitDone("timeout", 60, -1, w, ic);
        reqArr[1] = 1'b0;
        check("timeout_latency", 64'(w), 64'(SC + 2 + TO));
        @(negedge CLK);
        check("timeout_idle_gnt", 64'(gnt), 64'(0));
        check("timeout_idle_err", 64'(err), 64'(0));

        // Owner drops req during LAUNCH; zero-segment select
        busy = 1'b0;
        OPRr = 16'h2468;
        setReq(0, 3'd6, 16'h0ABC, 16'h0000, 1'b0, 1'b0, 1'b0);
        pushExp(0, 16'h2468, 1'b1, 1'b0);
        @(negedge CLK);
        reqArr[0] = 1'b0;
        waitDone("drop", 40, -1, w, ic);
        check("drop_strobe_rest", 64'(ic), 64'(SC - 1));
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (indirect || |gnt) cnt++;
        end
        check("drop_no_relaunch", 64'(cnt), 64'(0));

        // Reset while in WAIT
        busy = 1'b1;
        setReq(2, 3'd1, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b1);
        repeat (SC + 3) @(negedge CLK);
        check("midrst_busy_gnt", 64'(gnt), 64'(3'b100));
        RESET_n   = 1'b0;
        reqArr[2] = 1'b0;
        @(negedge CLK);
        checkReset("midrst");
        RESET_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (|done) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'(0));
        busy = 1'b0;
        OPRr = 16'hC0DE;
        setReq(2, 3'd1, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b1);
        pushExp(2, 16'hC0DE, 1'b1, 1'b0);
        waitDone("fresh", 40, -1, w, ic);
        reqArr[2] = 1'b0;
        check("fresh_latency", 64'(w), 64'(SC + 3));
        check("sb_empty", 64'(sbq.size()), 64'(0));
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
